// File: rtl/pipe_mon_pkg.sv
// Shared definitions for the pipeline trace monitor: entry layout, kind codes,
// counter indices and the monitor FSM state type.
package pipe_mon_pkg;
  localparam int ENTRY_W = 70;
  localparam int OVF_BIT = 3;
  localparam int N_CNT   = 8;

  localparam logic [1:0] KIND_WB = 2'b01;
  localparam logic [1:0] KIND_ST = 2'b10;

  localparam logic [2:0] CNT_CYC      = 3'd0;
  localparam logic [2:0] CNT_WB       = 3'd1;
  localparam logic [2:0] CNT_ST       = 3'd2;
  localparam logic [2:0] CNT_STALL    = 3'd3;
  localparam logic [2:0] CNT_STALL_LD = 3'd4;
  localparam logic [2:0] CNT_FLUSH    = 3'd5;
  localparam logic [2:0] CNT_MISS     = 3'd6;
  localparam logic [2:0] CNT_DROP     = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} mon_state_e;

  function automatic logic [ENTRY_W-1:0] mk_entry(input logic [1:0] kind,
                                                  input logic [31:0] tag,
                                                  input logic [31:0] val);
    return {kind, tag, val, 1'b0, 3'b000};
  endfunction
endpackage

// File: rtl/trace_fifo2w.sv
// Two-write / one-read circular trace buffer. Port 0 is ordered ahead of port 1.
// OVF_MODE 0 drops excess pushes; OVF_MODE 1 overwrites the oldest and marks the new head.
module trace_fifo2w
  import pipe_mon_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int OVF_MODE = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_push0,
  input  logic               i_push1,
  input  logic [ENTRY_W-1:0] i_d0,
  input  logic [ENTRY_W-1:0] i_d1,
  input  logic               i_pop,
  output logic               o_valid,
  output logic [ENTRY_W-1:0] o_data,
  output logic [1:0]         o_drop
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW+1:0] DEPTH_V = (AW+2)'(DEPTH);

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]      r_wptr, r_rptr;
  logic [AW:0]        r_count;
  logic               r_ovf;

  logic               w_pop;
  logic [1:0]         w_n, w_acc, w_kill, w_drop;
  logic [AW+1:0]      w_free;
  logic [ENTRY_W-1:0] w_e0, w_head;

  // Free space includes the slot vacated by a same-cycle pop.
  always_comb begin
    w_pop  = i_pop && (r_count != '0);
    w_n    = {1'b0, i_push0} + {1'b0, i_push1};
    w_free = DEPTH_V - {1'b0, r_count} + {{(AW+1){1'b0}}, w_pop};
    w_e0   = i_push0 ? i_d0 : i_d1;
    w_acc  = w_n;
    w_kill = '0;
    w_drop = '0;
    if ({{AW{1'b0}}, w_n} > w_free) begin
      if (OVF_MODE == 1) begin
        w_kill = w_n - w_free[1:0];
      end else begin
        w_acc  = w_free[1:0];
        w_drop = w_n - w_free[1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_wptr  <= r_wptr + AW'(w_acc);
      r_rptr  <= r_rptr + AW'(w_pop) + AW'(w_kill);
      r_count <= r_count + (AW+1)'(w_acc) - (AW+1)'(w_pop) - (AW+1)'(w_kill);
      if (w_kill != '0) r_ovf <= 1'b1;
      else if (w_pop)   r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_acc != '0)    r_mem[r_wptr]          <= w_e0;
    if (w_acc == 2'd2)  r_mem[r_wptr + AW'(1)] <= i_d1;
  end

  always_comb begin
    w_head          = r_mem[r_rptr];
    w_head[OVF_BIT] = r_ovf;
    o_valid         = (r_count != '0);
    o_data          = o_valid ? w_head : '0;
    o_drop          = w_drop;
  end
endmodule

// File: rtl/pipe_trace_monitor.sv
// Passive observer for the 5-stage core: trace capture, event counters, halt detect.
// Optional retire signature enabled by defining PIPE_MON_SIG_EN.
module pipe_trace_monitor
  import pipe_mon_pkg::*;
#(
  parameter int TRACE_DEPTH = 16,
  parameter int CNT_W       = 32,
  parameter int HALT_CYC    = 8,
  parameter int OVF_MODE    = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [31:0]        pc,
  input  logic               wb_we,
  input  logic [4:0]         wb_rd,
  input  logic [31:0]        wb_data,
  input  logic               st_we,
  input  logic [31:0]        st_addr,
  input  logic [31:0]        st_data,
  input  logic               stall,
  input  logic               stall_ld,
  input  logic               flush,
  input  logic               miss,
  output logic               tr_valid,
  input  logic               tr_ready,
  output logic [ENTRY_W-1:0] tr_data,
  input  logic [2:0]         cnt_sel,
  output logic [CNT_W-1:0]   cnt_q,
  output logic               halted,
  output logic [31:0]        sig
);
  localparam int HW = $clog2(HALT_CYC + 1);

  mon_state_e       r_state, w_state_nxt;
  logic [31:0]      r_prev_pc;
  logic [HW-1:0]    r_stab, w_stab_nxt;
  logic             w_run, w_cap_wb, w_cap_st, w_halt_hit;
  logic [1:0]       w_drop;
  logic [1:0]       w_inc [N_CNT];
  logic [CNT_W-1:0] r_cnt [N_CNT];
  logic [CNT_W-1:0] r_cnt_q;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  assign w_run    = (r_state == S_RUN);
  assign w_cap_wb = w_run && wb_we && (wb_rd != 5'd0);
  assign w_cap_st = w_run && st_we;

  // Run length of un-stalled cycles on the same pc; a new pc starts a run of one.
  always_comb begin
    w_stab_nxt = '0;
    if (stall || stall_ld)   w_stab_nxt = '0;
    else if (pc != r_prev_pc) w_stab_nxt = HW'(1);
    else                      w_stab_nxt = r_stab + HW'(1);
    w_halt_hit = w_run && !stall && !stall_ld && (w_stab_nxt == HW'(HALT_CYC));
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (en) w_state_nxt = S_RUN;
      S_RUN:   if (!en) w_state_nxt = S_IDLE;
               else if (w_halt_hit) w_state_nxt = S_HALT;
      S_HALT:  w_state_nxt = S_HALT;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_stab    <= '0;
      r_prev_pc <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_stab    <= w_run ? w_stab_nxt : '0;
      r_prev_pc <= pc;
    end
  end

  always_comb begin
    for (int i = 0; i < N_CNT; i++) w_inc[i] = 2'd0;
    if (w_run) begin
      w_inc[CNT_CYC]      = 2'd1;
      w_inc[CNT_WB]       = {1'b0, w_cap_wb};
      w_inc[CNT_ST]       = {1'b0, w_cap_st};
      w_inc[CNT_STALL]    = {1'b0, stall};
      w_inc[CNT_STALL_LD] = {1'b0, stall_ld};
      w_inc[CNT_FLUSH]    = {1'b0, flush};
      w_inc[CNT_MISS]     = {1'b0, miss};
      w_inc[CNT_DROP]     = w_drop;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CNT; i++) r_cnt[i] <= '0;
      r_cnt_q <= '0;
    end else begin
      for (int i = 0; i < N_CNT; i++) r_cnt[i] <= sat_add(r_cnt[i], w_inc[i]);
      r_cnt_q <= r_cnt[cnt_sel];
    end
  end

  trace_fifo2w #(.DEPTH(TRACE_DEPTH), .OVF_MODE(OVF_MODE)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push0 (w_cap_wb),
    .i_push1 (w_cap_st),
    .i_d0    (mk_entry(KIND_WB, {27'b0, wb_rd}, wb_data)),
    .i_d1    (mk_entry(KIND_ST, st_addr, st_data)),
    .i_pop   (tr_ready),
    .o_valid (tr_valid),
    .o_data  (tr_data),
    .o_drop  (w_drop)
  );

  assign cnt_q  = r_cnt_q;
  assign halted = (r_state == S_HALT);

`ifdef PIPE_MON_SIG_EN
  logic [31:0] r_sig;
  always_ff @(posedge clk) begin
    if (rst)           r_sig <= '0;
    else if (w_cap_wb) r_sig <= {r_sig[30:0], r_sig[31]} ^ wb_data ^ {27'b0, wb_rd};
  end
  assign sig = r_sig;
`else
  assign sig = 32'b0;
`endif
endmodule

// File: tb/tb_pipe_trace_monitor.sv
// Directed bench for pipe_trace_monitor: two instances (drop and overwrite
// overflow modes) share one stimulus stream; CNT_W=8 so saturation is reachable.
module tb_pipe_trace_monitor;
  logic        clk = 1'b0;
  logic        rst, en, wb_we, st_we, stall, stall_ld, flush, miss, tr_ready;
  logic [31:0] pc, wb_data, st_addr, st_data;
  logic [4:0]  wb_rd;
  logic [2:0]  cnt_sel;
  logic        tr_valid0, tr_valid1, halted0, halted1;
  logic [69:0] tr_data0, tr_data1;
  logic [7:0]  cnt_q0, cnt_q1;
  logic [31:0] sig0, sig1;
  logic        pc_auto;
  int          n_assert = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  pipe_trace_monitor #(.TRACE_DEPTH(16), .CNT_W(8), .HALT_CYC(8), .OVF_MODE(0)) u0 (
    .clk(clk), .rst(rst), .en(en), .pc(pc), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .st_we(st_we), .st_addr(st_addr), .st_data(st_data), .stall(stall), .stall_ld(stall_ld),
    .flush(flush), .miss(miss), .tr_valid(tr_valid0), .tr_ready(tr_ready), .tr_data(tr_data0),
    .cnt_sel(cnt_sel), .cnt_q(cnt_q0), .halted(halted0), .sig(sig0));

  pipe_trace_monitor #(.TRACE_DEPTH(16), .CNT_W(8), .HALT_CYC(8), .OVF_MODE(1)) u1 (
    .clk(clk), .rst(rst), .en(en), .pc(pc), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .st_we(st_we), .st_addr(st_addr), .st_data(st_data), .stall(stall), .stall_ld(stall_ld),
    .flush(flush), .miss(miss), .tr_valid(tr_valid1), .tr_ready(tr_ready), .tr_data(tr_data1),
    .cnt_sel(cnt_sel), .cnt_q(cnt_q1), .halted(halted1), .sig(sig1));

  function automatic logic [69:0] ent(input logic [1:0] k, input logic [31:0] t,
                                      input logic [31:0] v, input logic o);
    return {k, t, v, o, 3'b000};
  endfunction

  task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: pc advances unless held, outputs sampled 1ns after the edge.
  task automatic tick();
    if (pc_auto) pc = pc + 32'd4;
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; en = 0; pc = 32'h1000; pc_auto = 1; wb_we = 0; wb_rd = 0; wb_data = 0;
    st_we = 0; st_addr = 0; st_data = 0; stall = 0; stall_ld = 0; flush = 0; miss = 0;
    tr_ready = 0; cnt_sel = 0;
    ticks(2);
    chk("rst_valid",  tr_valid0, 0);
    chk("rst_data",   tr_data0, 0);
    chk("rst_cnt_q",  cnt_q0, 0);
    chk("rst_halted", halted0, 0);
    chk("rst_sig",    sig0, 0);

    // single WB capture
    rst = 0; en = 1; tick();
    wb_we = 1; wb_rd = 5; wb_data = 32'h2A; tr_ready = 1; tick();
    wb_we = 0;
    chk("wb_valid", tr_valid0, 1);
    chk("wb_entry", tr_data0, ent(2'b01, 32'd5, 32'h2A, 1'b0));
    cnt_sel = 1; tick();
    chk("wb_cnt", cnt_q0, 1);
    chk("wb_popped", tr_valid0, 0);

    // WB and store in the same cycle
    tr_ready = 0; wb_we = 1; wb_rd = 3; wb_data = 7; st_we = 1; st_addr = 32'h40; st_data = 9;
    tick();
    wb_we = 0; st_we = 0;
    chk("dual_first", tr_data0, ent(2'b01, 32'd3, 32'd7, 1'b0));
    tr_ready = 1; cnt_sel = 2; tick();
    chk("dual_second", tr_data0, ent(2'b10, 32'h40, 32'd9, 1'b0));
    chk("st_cnt", cnt_q0, 1);
    tick();
    chk("dual_empty", tr_valid0, 0);

    // rd=0 writes are not traced
    wb_we = 1; wb_rd = 0; wb_data = 32'h55; tick();
    wb_we = 0; tick();
    chk("rd0_ignored", tr_valid0, 0);

    // overflow: 20 pushes into 16 entries with no consumer
    tr_ready = 0;
    for (int i = 0; i < 20; i++) begin
      wb_we = 1; wb_rd = 5'(i + 1); wb_data = 32'h100 + 32'(i); tick();
    end
    wb_we = 0;
    chk("drop_head", tr_data0, ent(2'b01, 32'd1, 32'h100, 1'b0));
    chk("ovw_head",  tr_data1, ent(2'b01, 32'd5, 32'h104, 1'b1));
    cnt_sel = 7; tick();
    chk("drop_cnt", cnt_q0, 4);
    chk("ovw_drop_cnt", cnt_q1, 0);
    tr_ready = 1; tick();
    chk("drop_head2", tr_data0, ent(2'b01, 32'd2, 32'h101, 1'b0));
    chk("ovw_head2",  tr_data1, ent(2'b01, 32'd6, 32'h105, 1'b0));
    ticks(14);
    chk("drop_last", tr_data0, ent(2'b01, 32'd16, 32'h10F, 1'b0));
    chk("ovw_last",  tr_data1, ent(2'b01, 32'd20, 32'h113, 1'b0));
    tick();
    chk("drop_drained", tr_valid0, 0);
    chk("ovw_drained",  tr_valid1, 0);

    // event counters
    stall_ld = 1; ticks(3); stall_ld = 0;
    flush = 1; tick(); flush = 0;
    miss = 1; tick(); miss = 0; tick(); miss = 1; tick(); miss = 0;
    stall = 1; ticks(2); stall = 0;
    cnt_sel = 4;
    chk("cnt_latency", cnt_q0, 4);
    tick(); chk("cnt_stall_ld", cnt_q0, 3);
    cnt_sel = 5; tick(); chk("cnt_flush", cnt_q0, 1);
    cnt_sel = 6; tick(); chk("cnt_miss", cnt_q0, 2);
    cnt_sel = 3; tick(); chk("cnt_stall", cnt_q0, 2);

    // cycle counter saturates instead of wrapping
    cnt_sel = 0; ticks(260);
    chk("cyc_sat", cnt_q0, 8'hFF);

    // pause: en low returns to IDLE, no capture, counters kept
    en = 0; tick();
    wb_we = 1; wb_rd = 9; wb_data = 1; tick(); wb_we = 0; tick();
    chk("pause_nocap", tr_valid0, 0);
    cnt_sel = 4; tick();
    chk("pause_kept", cnt_q0, 3);
    en = 1; tick();

    // halt detect with a restart by stall_ld
    pc_auto = 0; pc = 32'h30;
    ticks(4);
    stall_ld = 1; tick(); stall_ld = 0;
    ticks(7);
    chk("halt_restart", halted0, 0);
    tick();
    chk("halt_set", halted0, 1);
    wb_we = 1; wb_rd = 4; wb_data = 2; tick(); wb_we = 0;
    en = 0; cnt_sel = 1; tick(); tick();
    chk("halt_nocap", tr_valid0, 0);
    chk("halt_wb_frozen", cnt_q0, 22);
    chk("halt_hold", halted0, 1);

    // reset mid-operation with five queued entries
    rst = 1; tick(); rst = 0; en = 1; pc_auto = 1; tick();
    tr_ready = 0;
    for (int i = 0; i < 5; i++) begin
      wb_we = 1; wb_rd = 5'(i + 1); wb_data = 32'(i); tick();
    end
    wb_we = 0;
    chk("pre_rst_valid", tr_valid0, 1);
    rst = 1; tick();
    chk("post_rst_valid", tr_valid0, 0);
    chk("post_rst_halted", halted0, 0);
    rst = 0; en = 0; cnt_sel = 1; tick();
    chk("post_rst_wb_cnt", cnt_q0, 0);
    cnt_sel = 0; tick(); tick();
    chk("post_rst_idle_cyc", cnt_q0, 0);
    chk("final_sig", sig0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
